rr_stream_mux: RTL and testbench
================================

Name: rr_stream_mux

Overview:
- Parametrised successor to the 4:1 selector mux: NUM_CH input channels of DATA_W bits each, with valid/ready handshakes.
- Selects among the channels with a round-robin arbiter instead of an external select.
- Registers the winner into a one-entry output stage.
- Sits between multiple producers and a single downstream consumer that may stall.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 8, width of each channel's data word.
- CH_W (localparam), $clog2(NUM_CH), width of the channel index. Minimum 1.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  NUM_CH  per-channel request; bit i belongs to channel i.
- in_data  input  NUM_CH*DATA_W  packed data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  per-channel accept, at most one bit high (one-hot or zero).
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  registered selected word.
- out_ch  output  CH_W  index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts the current word.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - out_valid=0, out_data=0, out_ch=0.
  - Priority pointer set so channel 0 has highest priority (last_grant=NUM_CH-1).
  - A word held mid-operation is discarded. No transfer completes on the cycle rst_n deasserts.
- Output stage has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- Load condition: load = !out_valid | out_ready.
  - The output register may accept a new word in EMPTY, or in FULL when the held word is drained the same cycle.
- Arbitration (combinational):
  - Search channels starting at last_grant+1, wrapping modulo NUM_CH.
  - The first channel with in_valid=1 is the grant g.
  - in_ready[g] = load. All other in_ready bits = 0.
  - With no valid inputs, in_ready = 0.
- Transfer: in_valid[g] & in_ready[g] at a rising edge:
  - out_data <= word of channel g; out_ch <= g; out_valid <= 1; last_grant <= g.
- Drain without refill: out_valid & out_ready with no input transfer -> out_valid <= 0. out_data and out_ch hold their old values.
- Simultaneous drain and refill: the register reloads the same cycle, sustaining 1 word/cycle throughput.
- Stall: while out_valid=1 and out_ready=0:
  - out_data and out_ch stay stable.
  - All in_ready = 0.
  - last_grant does not change.
- Latency: an accepted input appears on out_data exactly 1 cycle after its handshake edge.
- Fairness:
  - last_grant updates only on a completed transfer.
  - With all channels continuously valid and out_ready=1, grants cycle 0,1,..,NUM_CH-1,0.
  - A continuously valid channel waits at most NUM_CH-1 transfers.
- Input rule: a producer must hold in_valid and its data until in_ready. The block does not check this.
- in_ready must never depend combinationally on in_valid of an ungranted channel in a way that creates a loop. out_ready -> in_ready is the only combinational path from the output side.

Optional Feature:
- Macro: RR_STREAM_MUX_FORCE_EN.
- When defined, adds two ports:
  - force_en  input  1.
  - force_sel  input  CH_W.
- With force_en=1:
  - Grant is force_sel if in_valid[force_sel]=1, else no grant.
  - last_grant is not updated.
  - The block acts as a plain registered N:1 select mux with handshake.
- With force_en=0: round-robin behaviour as above.
- When not defined: the ports do not exist and behaviour is pure round-robin.

Test Plan:
1. Reset then idle: rst_n low 2 cycles, all in_valid=0 -> out_valid=0, out_data=0, out_ch=0, in_ready=4'b0000.
2. Single channel: in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
3. Round-robin, NUM_CH=4:
   - Stimulus: all valid, data ch0..3 = 8'h10,8'h21,8'h32,8'h43, out_ready=1 for 8 cycles.
   - Response: out_ch sequence 0,1,2,3,0,1,2,3; out_data matches each channel.
4. Backpressure:
   - Stimulus: load 8'h5A from ch1, then out_ready=0 for 3 cycles.
   - Response: out_data=8'h5A and out_ch=1 stable; in_ready=0; last_grant stays 1.
   - On out_ready=1 with ch3 valid: next out_ch=3.
5. Reset mid-operation: out_valid=1 holding 8'h77, pull rst_n low between clock edges -> out_valid=0, out_data=0 immediately. After release, ch0 wins first.
6. Force mode (RR_STREAM_MUX_FORCE_EN defined):
   - Stimulus: force_en=1, force_sel=3, all valid.
   - Response: every transfer out_ch=3.
   - With force_sel=1 and in_valid[1]=0: in_ready=0 and out_valid drains to 0.

Source files
------------

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: round-robin N:1 stream mux with a one-entry registered output stage.
// Optional build macro RR_STREAM_MUX_FORCE_EN adds force_en/force_sel for a fixed-select mode.
module rr_stream_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
`ifdef RR_STREAM_MUX_FORCE_EN
    input  logic                     force_en,
    input  logic [CH_W-1:0]          force_sel,
`endif
    input  logic                     out_ready
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t          state, state_nxt;
    logic [CH_W-1:0] last_grant, grant;
    logic            any, hold_ptr, load, xfer;
    int              idx;
    // Grant search starts just after the last winner and wraps, so the nearest requester wins
    always_comb begin
        grant    = '0;
        any      = 1'b0;
        hold_ptr = 1'b0;
        idx      = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (in_valid[idx[CH_W-1:0]]) begin
                grant = idx[CH_W-1:0];
                any   = 1'b1;
            end
        end
`ifdef RR_STREAM_MUX_FORCE_EN
        if (force_en) begin
            hold_ptr = 1'b1;
            grant    = force_sel;
            any      = (int'(force_sel) < NUM_CH) && in_valid[force_sel];
        end
`endif
    end
    assign load     = (state == EMPTY) | out_ready;
    assign xfer     = any & load;
    assign in_ready = xfer ? {{(NUM_CH-1){1'b0}}, 1'b1} << grant : '0;
    // Output stage state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end
    // Refill wins over drain so back-to-back words sustain one per cycle
    always_comb state_nxt = xfer ? FULL : (out_ready ? EMPTY : state);
    // Output stage flags
    always_comb out_valid = (state == FULL);
    // Capture the winning word and advance the priority pointer on each transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (xfer) begin
            out_data   <= in_data[grant*DATA_W +: DATA_W];
            out_ch     <= grant;
            last_grant <= hold_ptr ? last_grant : grant;
        end
    end
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: scoreboard bench for rr_stream_mux (NUM_CH=4, DATA_W=8).
module tb_rr_stream_mux;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_valid = '0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready = 1'b0;
`ifdef RR_STREAM_MUX_FORCE_EN
    logic        force_en = 1'b0;
    logic [1:0]  force_sel = '0;
`endif
    int checks = 0;
    int errors = 0;
    logic [9:0] q[$];
    int seen[$];
    bit m_valid = 1'b0;
    int m_last = 3;

    rr_stream_mux #(.NUM_CH(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
`ifdef RR_STREAM_MUX_FORCE_EN
        .force_en(force_en), .force_sel(force_sel),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model and scoreboard, evaluated mid-cycle with inputs stable
    always @(negedge clk) begin
        bit any;
        int g;
        bit hold;
        logic [3:0] exp_ready;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_last = 3;
            q.delete();
            check("rst_out_valid", {31'b0, out_valid}, 32'd0);
            check("rst_out_data", {24'b0, out_data}, 32'd0);
            check("rst_out_ch", {30'b0, out_ch}, 32'd0);
        end else begin
            check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            if (m_valid && q.size() > 0) begin
                check("out_data", {24'b0, out_data}, {24'b0, q[0][7:0]});
                check("out_ch", {30'b0, out_ch}, {30'b0, q[0][9:8]});
                if (out_ready) begin
                    seen.push_back(int'(q[0][9:8]));
                    void'(q.pop_front());
                end
            end
            any = 1'b0;
            g = 0;
            hold = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (in_valid[c] && !any) begin
                    any = 1'b1;
                    g = c;
                end
            end
`ifdef RR_STREAM_MUX_FORCE_EN
            if (force_en) begin
                hold = 1'b1;
                g = int'(force_sel);
                any = in_valid[force_sel];
            end
`endif
            any = any && (!m_valid || out_ready);
            exp_ready = any ? 4'(1 << g) : 4'b0;
            check("in_ready", {28'b0, in_ready}, {28'b0, exp_ready});
            if (any) begin
                q.push_back({g[1:0], in_data[g*8 +: 8]});
                if (!hold) m_last = g;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        // 1: reset then idle
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("idle_out_valid", {31'b0, out_valid}, 32'd0);
        check("idle_out_data", {24'b0, out_data}, 32'd0);
        check("idle_in_ready", {28'b0, in_ready}, 32'd0);
        // 3: round-robin with all channels valid
        seen.delete();
        in_data = {8'h43, 8'h32, 8'h21, 8'h10};
        in_valid = 4'b1111;
        out_ready = 1'b1;
        repeat (8) tick();
        in_valid = 4'b0000;
        tick();
        check("rr_count", seen.size(), 32'd8);
        foreach (seen[i]) check("rr_order", seen[i], i % 4);
        // 2: single channel
        in_data = 32'h00A5_0000;
        in_valid = 4'b0100;
        #1;
        check("single_in_ready", {28'b0, in_ready}, 32'h4);
        tick();
        in_valid = 4'b0000;
        check("single_out_valid", {31'b0, out_valid}, 32'd1);
        check("single_out_data", {24'b0, out_data}, 32'hA5);
        check("single_out_ch", {30'b0, out_ch}, 32'd2);
        tick();
        // 4: backpressure
        in_data = 32'h9900_5A00;
        in_valid = 4'b0010;
        tick();
        in_valid = 4'b1000;
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            check("stall_out_data", {24'b0, out_data}, 32'h5A);
            check("stall_out_ch", {30'b0, out_ch}, 32'd1);
            check("stall_in_ready", {28'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 4'b0000;
        check("after_stall_out_ch", {30'b0, out_ch}, 32'd3);
        check("after_stall_out_data", {24'b0, out_data}, 32'h99);
        tick();
        // 5: reset mid-operation
        in_data = 32'h0000_0077;
        in_valid = 4'b0001;
        tick();
        in_valid = 4'b0000;
        out_ready = 1'b0;
        check("pre_rst_out_data", {24'b0, out_data}, 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_out_data", {24'b0, out_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        in_data = {8'h43, 8'h32, 8'h21, 8'h10};
        in_valid = 4'b1111;
        out_ready = 1'b1;
        tick();
        in_valid = 4'b0000;
        check("post_rst_first_ch", {30'b0, out_ch}, 32'd0);
        tick();
`ifdef RR_STREAM_MUX_FORCE_EN
        // 6: forced select
        force_en = 1'b1;
        force_sel = 2'd3;
        in_valid = 4'b1111;
        repeat (4) begin
            tick();
            check("force_out_ch", {30'b0, out_ch}, 32'd3);
        end
        force_sel = 2'd1;
        in_valid = 4'b1101;
        #1;
        check("force_in_ready", {28'b0, in_ready}, 32'd0);
        tick();
        check("force_drained", {31'b0, out_valid}, 32'd0);
        force_en = 1'b0;
        in_valid = 4'b0000;
        tick();
`endif
        tick();
        check("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
